core_sequencer: RTL

//   Multi-cycle control FSM for the RV32I core: fetches into the instruction register, then steps execute/memory/writeback.

---
 rtl/core_pkg.sv | 53 +++++
 rtl/core_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer:
// FSM state codes, opcode classes and the opcode classifier.
package core_pkg;

  localparam logic [2:0] ST_FETCH       = 3'd0;
  localparam logic [2:0] ST_FETCH_WAIT  = 3'd1;
  localparam logic [2:0] ST_EXECUTE     = 3'd2;
  localparam logic [2:0] ST_MEMORY      = 3'd3;
  localparam logic [2:0] ST_MEMORY_WAIT = 3'd4;
  localparam logic [2:0] ST_WRITEBACK   = 3'd5;
  localparam logic [2:0] ST_TRAP        = 3'd7;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE
  } opc_class_e;

  function automatic opc_class_e classify(input logic [31:0] insn);
    opc_class_e cls;
    cls = CLS_ILLEGAL;
    if (insn[1:0] == 2'b11) begin
      case (insn[6:2])
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_JAL:    cls = CLS_JUMP;
        OPC_JALR:   cls = CLS_JUMP;
        OPC_OP:     cls = CLS_ALU;
        OPC_OP_IMM: cls = CLS_ALU;
        OPC_LUI:    cls = CLS_ALU;
        OPC_AUIPC:  cls = CLS_ALU;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, execute, memory, writeback.
// Owns pc, instruction register and the retired-instruction counter.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            dmem_req_valid,
  output logic            dmem_req_write,
  input  logic            dmem_req_ready,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] pc_target,
  input  logic            branch_taken,
  output logic [31:0]     instruction_reg,
  output logic [XLEN-1:0] pc,
  output logic            regfile_write_strobe,
  output logic            mem_to_reg_select,
  output logic [2:0]      state,
  output logic            illegal_instruction,
  output logic [31:0]     instret
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     instret_q, instret_d;
  logic [XLEN-1:0] pc_plus4;
  logic            tgt_ok;
  logic            retire;
  opc_class_e      cls;

  assign cls      = classify(ir_q);
  assign pc_plus4 = pc_q + XLEN'(4);
  assign tgt_ok   = (pc_target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_req_ready) state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (imem_resp_valid) begin
          ir_d    = imem_resp_data;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        unique case (cls)
          CLS_BRANCH: begin
            // misaligned taken target traps with pc left on the branch
            if (branch_taken && !tgt_ok) begin
              state_d = ST_TRAP;
            end else begin
              pc_d    = branch_taken ? pc_target : pc_plus4;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
          end
          CLS_JUMP: begin
            if (!tgt_ok) begin
              state_d = ST_TRAP;
            end else begin
              pc_d    = pc_target;
              state_d = ST_WRITEBACK;
            end
          end
          CLS_ALU: begin
            pc_d    = pc_plus4;
            state_d = ST_WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = ST_MEMORY;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_req_ready) state_d = ST_MEMORY_WAIT;
      end
      ST_MEMORY_WAIT: begin
        if (dmem_resp_valid) begin
          pc_d = pc_plus4;
          if (cls == CLS_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_VECTOR[XLEN-1:0];
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // fetch request is masked while reset is held so no valid leaks out
  assign imem_req_valid       = (state_q == ST_FETCH) && rst_n;
  assign imem_req_addr        = pc_q;
  assign dmem_req_valid       = (state_q == ST_MEMORY);
  assign dmem_req_write       = dmem_req_valid && (cls == CLS_STORE);
  assign regfile_write_strobe = (state_q == ST_WRITEBACK) && (ir_q[11:7] != 5'd0);
  assign mem_to_reg_select    = (state_q == ST_WRITEBACK) && (cls == CLS_LOAD);
  assign illegal_instruction  = (state_q == ST_TRAP);
  assign state                = state_q;
  assign instruction_reg      = ir_q;
  assign pc                   = pc_q;
  assign instret              = instret_q;

endmodule
